bnn_layer_ctrl: RTL and testbench
=================================

BNN_LAYER_CTRL -- requirements
Module: bnn_layer_ctrl

Interface
REQ-001 SHALL have parameter WL, default 112: bits per chunk, equal to the popcount datapath width.
REQ-002 SHALL have parameter N_CHUNK, default 4: chunks per neuron, range 1..255.
REQ-003 SHALL have parameter N_NEURON, default 64: neurons per layer, range 1..255.
REQ-004 SHALL have parameter AW, default 16: width of the weight address.
REQ-005 SHALL have port iCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port iRSTn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port iSTART, input, 1 bit: starts a layer when the block is in IDLE.
REQ-008 SHALL have port oRD_EN, output, 1 bit: read strobe to the data and weight memories, which have 1-cycle read latency.
REQ-009 SHALL have port oDATA_ADDR, output, 8 bits: input-vector chunk index.
REQ-010 SHALL have port oWGT_ADDR, output, AW bits: weight address, neuron*N_CHUNK+chunk.
REQ-011 SHALL have port oPC_EN, output, 1 bit: iEN to the popcount unit; equals oRD_EN delayed by 1 cycle.
REQ-012 SHALL have port iPC_VALID, input, 1 bit: oEN from the popcount unit (variable fixed latency).
REQ-013 SHALL have port iPC_DATA, input, 11 bits: popcount result.
REQ-014 SHALL have port iTHRESH, input, 16 bits: threshold for the neuron indexed by oNEURON.
REQ-015 SHALL have port oNEURON, output, 8 bits: current neuron index.
REQ-016 SHALL have port oOUT_WE, output, 1 bit: output bit write strobe.
REQ-017 SHALL have port oOUT_BIT, output, 1 bit: binarized neuron output.
REQ-018 SHALL have port oBUSY, output, 1 bit: high in every state other than IDLE.
REQ-019 SHALL have port oDONE, output, 1 bit: one-cycle pulse at layer end.

Function
REQ-020 SHALL implement the states IDLE, ISSUE, DRAIN, WRITE and FINISH.
REQ-021 In IDLE, iSTART=1 SHALL clear neuron, chunk, issue-count, return-count and the accumulator, then move to ISSUE; iSTART outside IDLE SHALL be ignored.
REQ-022 In ISSUE, oRD_EN SHALL be 1 for exactly N_CHUNK consecutive cycles, with oDATA_ADDR = chunk = 0..N_CHUNK-1; after the last issue the block SHALL move to DRAIN.
REQ-023 While ISSUE and DRAIN are active, each cycle with iPC_VALID=1 SHALL add zero-extended iPC_DATA to the 16-bit accumulator and increment return-count.
REQ-024 The accumulator SHALL saturate at 16'hFFFF.
REQ-025 iPC_VALID while in IDLE, WRITE or FINISH SHALL be ignored.
REQ-026 Once return-count reaches N_CHUNK, the block SHALL go to WRITE on the next cycle, including when the last return coincides with the last issue.
REQ-027 WRITE SHALL last 1 cycle: oOUT_WE=1 and oOUT_BIT = (acc >= iTHRESH), compared unsigned.
REQ-028 After WRITE, if neuron < N_NEURON-1: neuron increments, acc/chunk/return-count clear, and the block goes to ISSUE; otherwise it goes to FINISH.
REQ-029 FINISH SHALL assert oDONE for 1 cycle and then return to IDLE.
REQ-030 Neurons SHALL never overlap: no issue for neuron n+1 until neuron n has been written.
REQ-031 oRD_EN, oOUT_WE and oDONE SHALL be registered outputs with no combinational path from the inputs.

Reset
REQ-032 While iRSTn=0, the state SHALL be IDLE and every output SHALL be 0: oRD_EN, oPC_EN, oDATA_ADDR, oWGT_ADDR, oNEURON, oOUT_WE, oOUT_BIT, oBUSY, oDONE; the accumulator and all counters SHALL also be 0.
REQ-033 Reset asserted mid-layer SHALL abort immediately with no oOUT_WE or oDONE pulse.
REQ-034 After reset deasserts, iPC_VALID pulses still in flight from the popcount unit SHALL be ignored while in IDLE.

Verification
REQ-035 N_CHUNK=4, N_NEURON=3, bench popcount latency 3, iPC_DATA=50 per chunk, iTHRESH=200 -> three WRITE pulses with oOUT_BIT=1 (acc=200); oDONE asserted once, 3*(4+1+3+1)+1 cycles after start.
REQ-036 Same setup with iTHRESH=201 -> oOUT_BIT=0 for all neurons; oWGT_ADDR sequence 0..11 with no gaps or repeats.
REQ-037 Popcount latency 0 (iPC_VALID in the same cycle as oPC_EN), N_CHUNK=1 -> WRITE the cycle after the single return; neuron count still correct.
REQ-038 iSTART held high through a layer and pulsed during DRAIN -> exactly one layer runs, and a second layer starts only if iSTART=1 in IDLE after oDONE.
REQ-039 iRSTn low during DRAIN of neuron 1, then a normal start -> no output pulses during or after reset until the new layer; the new layer's neuron 0 result is unaffected by stale returns.
REQ-040 iPC_DATA=2047 with N_CHUNK=40 -> accumulator saturates at 65535 and oOUT_BIT=1 for iTHRESH=65535.

Source files
------------

// File: rtl/bnn_layer_ctrl.sv
// Sequences one binarized-NN layer: issues chunk reads per neuron, accumulates popcounts, thresholds each neuron.
// Latency per neuron: N_CHUNK issue cycles + popcount latency + 2; layer done pulse 1 cycle after the last write.
// No backpressure: returns are accepted whenever they arrive in ISSUE/DRAIN; the next neuron waits for all returns.
module bnn_layer_ctrl #(
    parameter int WL       = 112,
    parameter int N_CHUNK  = 4,
    parameter int N_NEURON = 64,
    parameter int AW       = 16
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iSTART,
    output logic          oRD_EN,
    output logic [7:0]    oDATA_ADDR,
    output logic [AW-1:0] oWGT_ADDR,
    output logic          oPC_EN,
    input  logic          iPC_VALID,
    input  logic [10:0]   iPC_DATA,
    input  logic [15:0]   iTHRESH,
    output logic [7:0]    oNEURON,
    output logic          oOUT_WE,
    output logic          oOUT_BIT,
    output logic          oBUSY,
    output logic          oDONE
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [7:0] NC8         = 8'(N_CHUNK);
    localparam logic [7:0] LAST_CHUNK  = 8'(N_CHUNK - 1);
    localparam logic [7:0] LAST_NEURON = 8'(N_NEURON - 1);

    // The popcount result port is 11 bits wide, so a chunk can hold at most 2047 bits.
    if (WL > 2047) begin : g_wl_wider_than_pc_port
    end

    logic [2:0]    state_q, state_d;
    logic [7:0]    chunk_q, chunk_d;
    logic [7:0]    neuron_q, neuron_d;
    logic [7:0]    ret_q, ret_d;
    logic [15:0]   acc_q, acc_d;
    logic [AW-1:0] wgt_q, wgt_d;
    logic          rd_en_q;
    logic          pc_en_q;
    logic          out_we_q;
    logic          done_q;
    logic [16:0]   acc_sum;

    // Next-state logic: return accumulation plus the layer sequencing FSM.
    always_comb begin
        state_d  = state_q;
        chunk_d  = chunk_q;
        neuron_d = neuron_q;
        ret_d    = ret_q;
        acc_d    = acc_q;
        wgt_d    = wgt_q;
        acc_sum  = {1'b0, acc_q} + {6'b0, iPC_DATA};

        // Returns only count while a neuron is in flight; stale or stray pulses elsewhere are dropped.
        if ((state_q == S_ISSUE || state_q == S_DRAIN) && iPC_VALID) begin
            acc_d = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
            ret_d = ret_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (iSTART) begin
                    chunk_d  = 8'd0;
                    neuron_d = 8'd0;
                    ret_d    = 8'd0;
                    acc_d    = 16'd0;
                    wgt_d    = '0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Weight address runs linearly across neurons, so it simply counts issues.
                wgt_d = wgt_q + AW'(1);
                if (chunk_q == LAST_CHUNK) begin
                    state_d = (ret_d == NC8) ? S_WRITE : S_DRAIN;
                end else begin
                    chunk_d = chunk_q + 8'd1;
                end
            end
            S_DRAIN: begin
                if (ret_d == NC8) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (neuron_q < LAST_NEURON) begin
                    neuron_d = neuron_q + 8'd1;
                    chunk_d  = 8'd0;
                    ret_d    = 8'd0;
                    acc_d    = 16'd0;
                    state_d  = S_ISSUE;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and strobe registers; strobes are decoded from the next state so they align with it.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q  <= S_IDLE;
            chunk_q  <= 8'd0;
            neuron_q <= 8'd0;
            ret_q    <= 8'd0;
            acc_q    <= 16'd0;
            wgt_q    <= '0;
            rd_en_q  <= 1'b0;
            pc_en_q  <= 1'b0;
            out_we_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            chunk_q  <= chunk_d;
            neuron_q <= neuron_d;
            ret_q    <= ret_d;
            acc_q    <= acc_d;
            wgt_q    <= wgt_d;
            rd_en_q  <= (state_d == S_ISSUE);
            pc_en_q  <= rd_en_q;
            out_we_q <= (state_d == S_WRITE);
            done_q   <= (state_d == S_FINISH);
        end
    end

    assign oRD_EN     = rd_en_q;
    assign oPC_EN     = pc_en_q;
    assign oDATA_ADDR = chunk_q;
    assign oWGT_ADDR  = wgt_q;
    assign oNEURON    = neuron_q;
    assign oOUT_WE    = out_we_q;
    // The threshold belongs to the neuron on oNEURON, so compare against it during the write cycle.
    assign oOUT_BIT   = out_we_q && (acc_q >= iTHRESH);
    assign oBUSY      = (state_q != S_IDLE);
    assign oDONE      = done_q;

endmodule

// File: tb/tb_bnn_layer_ctrl.sv
module tb_bnn_layer_ctrl;

    logic        clk;
    logic        rstn;
    logic        st   [3];
    logic        pv   [3];
    logic [10:0] pd   [3];
    logic [15:0] th   [3];
    logic        rd   [3];
    logic        pce  [3];
    logic        we   [3];
    logic        ob   [3];
    logic        bz   [3];
    logic        dn   [3];
    logic [7:0]  da   [3];
    logic [7:0]  nr   [3];
    logic [15:0] wa   [3];

    // Three configurations: (4 chunks, 3 neurons), (1 chunk, 3 neurons), (40 chunks, 2 neurons)
    for (genvar g = 0; g < 3; g++) begin : g_dut
        bnn_layer_ctrl #(
            .WL(112),
            .N_CHUNK(g == 0 ? 4 : (g == 1 ? 1 : 40)),
            .N_NEURON(g == 2 ? 2 : 3),
            .AW(16)
        ) u_dut (
            .iCLK(clk), .iRSTn(rstn), .iSTART(st[g]),
            .oRD_EN(rd[g]), .oDATA_ADDR(da[g]), .oWGT_ADDR(wa[g]), .oPC_EN(pce[g]),
            .iPC_VALID(pv[g]), .iPC_DATA(pd[g]), .iTHRESH(th[g]),
            .oNEURON(nr[g]), .oOUT_WE(we[g]), .oOUT_BIT(ob[g]), .oBUSY(bz[g]), .oDONE(dn[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model state
    int         lat     [3];
    int         pp      [3];
    bit         act     [3];
    int         t0      [3];
    int         dexp    [3];
    logic       exp_rd_prev [3];
    logic       rd_last [3];
    logic [6:0] adr_last[3];
    logic       hrd     [3][16];
    logic [6:0] hadr    [3][16];
    int         pc_tab  [3][128];
    int         thr_tab [3][4];

    function automatic int ncf(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 40);
    endfunction

    function automatic int nnf(input int d);
        return (d == 2) ? 2 : 3;
    endfunction

    function automatic int sum_sat(input int d, input int n);
        longint s;
        s = 0;
        for (int c = 0; c < ncf(d); c++) s += pc_tab[d][n*ncf(d)+c];
        if (s > 65535) s = 65535;
        return int'(s);
    endfunction

    function automatic bit exp_bit(input int d, input int n);
        return sum_sat(d, n) >= thr_tab[d][n];
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0d expected=%0d", tag, d, cyc, obs, exp);
        end
    endtask

    // Advance one clock: drive popcount/threshold for the new cycle, then check every output.
    task automatic step();
        logic stp[3];
        logic rst_p;
        stp   = st;
        rst_p = rstn;
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (!rstn) begin
                act[d] = 1'b0;
            end else if (rst_p && stp[d] && (!act[d] || (cyc - 1) > dexp[d])) begin
                act[d]  = 1'b1;
                pp[d]   = ncf(d) + lat[d] + 2;
                t0[d]   = cyc - 1;
                dexp[d] = t0[d] + nnf(d) * pp[d] + 1;
            end
            for (int j = 15; j > 0; j--) begin
                hrd[d][j]  = hrd[d][j-1];
                hadr[d][j] = hadr[d][j-1];
            end
            hrd[d][0]  = rd_last[d];
            hadr[d][0] = adr_last[d];
            pv[d] = hrd[d][lat[d]];
            pd[d] = pv[d] ? 11'(pc_tab[d][hadr[d][lat[d]]]) : 11'($urandom);
            th[d] = 16'(thr_tab[d][nr[d][1:0]]);
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            if (!rstn) begin
                chk("rst_ctl", d, {26'd0, rd[d], pce[d], we[d], ob[d], bz[d], dn[d]}, 0);
                chk("rst_addr", d, {da[d], nr[d], wa[d]}, 0);
                exp_rd_prev[d] = 1'b0;
            end else begin
                int rel, ph, p;
                bit inl, erd, ewe;
                p   = pp[d];
                rel = cyc - t0[d];
                inl = act[d] && cyc > t0[d] && cyc <= dexp[d];
                ph  = inl ? (rel - 1) % p : 0;
                erd = inl && cyc < dexp[d] && ph < ncf(d);
                ewe = inl && cyc < dexp[d] && (rel % p) == 0;
                chk("busy", d, bz[d], inl);
                chk("done", d, dn[d], inl && cyc == dexp[d]);
                chk("rd_en", d, rd[d], erd);
                chk("out_we", d, we[d], ewe);
                chk("pc_en", d, pce[d], exp_rd_prev[d]);
                if (erd) begin
                    chk("wgt_addr", d, wa[d], ((rel - 1) / p) * ncf(d) + ph);
                    chk("data_addr", d, da[d], ph);
                end
                if (ewe) begin
                    chk("neuron", d, nr[d], rel / p - 1);
                    chk("out_bit", d, ob[d], exp_bit(d, rel / p - 1));
                end
                exp_rd_prev[d] = erd;
            end
            rd_last[d]  = rd[d];
            adr_last[d] = wa[d][6:0];
        end
    endtask

    function automatic bit busy_any();
        bit b;
        b = 1'b0;
        for (int d = 0; d < 3; d++) if (act[d] && cyc <= dexp[d]) b = 1'b1;
        return b;
    endfunction

    task automatic run(input int budget);
        int n;
        n = 0;
        while (n < budget && busy_any()) begin
            step();
            n++;
        end
        if (busy_any()) begin
            checks++;
            errors++;
            $error("FAIL timeout run observed=%0d expected=%0d", n, budget);
        end
        repeat (3) step();
    endtask

    task automatic set_st(input logic [2:0] m);
        for (int d = 0; d < 3; d++) st[d] = m[d];
    endtask

    task automatic launch(input logic [2:0] m);
        set_st(m);
        step();
        set_st(3'b000);
        run(2000);
    endtask

    // Step until DUT d reaches a given cycle offset into its current layer.
    task automatic wait_rel(input int d, input int target, input int budget);
        int n;
        n = 0;
        while (n < budget && !(act[d] && (cyc - t0[d]) == target)) begin
            step();
            n++;
        end
        if (!(act[d] && (cyc - t0[d]) == target)) begin
            checks++;
            errors++;
            $error("FAIL timeout wait_rel observed=%0d expected=%0d", cyc - t0[d], target);
        end
    endtask

    // mode < 0: random popcounts; otherwise every chunk returns mode
    task automatic fill(input int d, input int mode);
        for (int i = 0; i < 128; i++) pc_tab[d][i] = (mode < 0) ? int'($urandom_range(0, 2047)) : mode;
    endtask

    // Thresholds within +/-1 of the true sum so the comparison boundary is exercised.
    task automatic thr_near(input int d);
        for (int n = 0; n < 4; n++) begin
            int t;
            t = (n < nnf(d)) ? sum_sat(d, n) + int'($urandom_range(0, 2)) - 1 : 0;
            if (t < 0) t = 0;
            if (t > 65535) t = 65535;
            thr_tab[d][n] = t;
        end
    endtask

    task automatic thr_all(input int d, input int v);
        for (int n = 0; n < 4; n++) thr_tab[d][n] = v;
    endtask

    initial begin
        rstn = 1'b0;
        for (int d = 0; d < 3; d++) begin
            st[d] = 1'b0; pv[d] = 1'b0; pd[d] = 11'd0; th[d] = 16'd0;
            act[d] = 1'b0; t0[d] = 0; dexp[d] = 0; pp[d] = 3;
            exp_rd_prev[d] = 1'b0; rd_last[d] = 1'b0; adr_last[d] = 7'd0;
            for (int j = 0; j < 16; j++) begin hrd[d][j] = 1'b0; hadr[d][j] = 7'd0; end
            fill(d, 0);
            thr_all(d, 0);
        end
        lat[0] = 3; lat[1] = 0; lat[2] = 2;

        repeat (3) step();
        rstn = 1'b1;
        repeat (2) step();

        // 50 per chunk, threshold 200: every neuron exactly meets it; 40x2047 saturates
        fill(0, 50);   thr_all(0, 200);
        fill(1, -1);   thr_near(1);
        fill(2, 2047); thr_all(2, 65535);
        launch(3'b111);

        // One above the sum: all zeros
        thr_all(0, 201);
        fill(1, -1); thr_near(1);
        fill(2, -1); thr_near(2);
        launch(3'b111);

        // Randomized layers with varying popcount latency
        for (int it = 0; it < 5; it++) begin
            lat[0] = int'($urandom_range(0, 5));
            lat[2] = int'($urandom_range(0, 4));
            for (int d = 0; d < 3; d++) begin
                fill(d, -1);
                thr_near(d);
            end
            launch(3'b111);
        end

        // Start held high through a layer with a low pulse in DRAIN, dropped at FINISH
        lat[0] = 3;
        fill(0, -1); thr_near(0);
        set_st(3'b001);
        wait_rel(0, (6 + lat[0]) + 4 + 2, 200);
        set_st(3'b000);
        step();
        set_st(3'b001);
        wait_rel(0, 3 * (6 + lat[0]) + 1, 200);
        set_st(3'b000);
        repeat (10) step();

        // Start held through FINISH into IDLE: a second layer follows back to back
        fill(0, -1); thr_near(0);
        set_st(3'b001);
        wait_rel(0, 3 * (6 + lat[0]) + 1, 200);
        step();
        step();
        set_st(3'b000);
        run(400);

        // Reset during DRAIN of neuron 1, stale returns land in IDLE, then a clean layer
        fill(0, -1); thr_near(0);
        set_st(3'b001);
        step();
        set_st(3'b000);
        wait_rel(0, (6 + lat[0]) + 4 + 2, 200);
        rstn = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        repeat (8) step();
        fill(0, -1); thr_near(0);
        launch(3'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
